rs_issue_arbiter: RTL and testbench

// - N-channel oldest-first merge of reservation-station outputs into one execution unit.
// - Generalises the fixed 3-way GPR/SPR/CR merge to CHANNELS inputs.
// - Age is a wrap-around sequence tag, not the RS id.
// - Adds a registered issue stage (1-cycle latency, full throughput) between the stations and the unit.

---
 rtl/rs_issue_arbiter.sv | 154 +++++++++++++++
 tb/tb_rs_issue_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_arbiter.sv
// Oldest-first N-channel reservation-station merge feeding one execution unit
// via a registered issue stage. Optional starvation guard: RS_ARB_STARVE_GUARD_EN.
module rs_issue_arbiter #(
  parameter int CHANNELS     = 3,
  parameter int OP_WIDTH     = 32,
  parameter int RS_ID_WIDTH  = 5,
  parameter int CTRL_WIDTH   = 16,
  parameter int SEQ_WIDTH    = 6,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [0:CHANNELS-1]                    in_valid,
  output logic [0:CHANNELS-1]                    in_ready,
  input  logic [CHANNELS-1:0][RS_ID_WIDTH-1:0]   in_rs_id,
  input  logic [CHANNELS-1:0][SEQ_WIDTH-1:0]     in_seq,
  input  logic [CHANNELS-1:0][OP_WIDTH-1:0]      in_op,
  input  logic [CHANNELS-1:0][CTRL_WIDTH-1:0]    in_control,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RS_ID_WIDTH-1:0]                 out_rs_id,
  output logic [OP_WIDTH-1:0]                    out_op,
  output logic [CTRL_WIDTH-1:0]                  out_control,
  output logic [$clog2(CHANNELS)-1:0]            out_channel
);

  localparam int CH_W = $clog2(CHANNELS);

  if (CHANNELS < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("rs_issue_arbiter: CHANNELS must be >= 2 and STARVE_LIMIT >= 1");
  end

  // Wrap-safe age compare: a is older than b when (a-b) has its top bit set.
  function automatic logic is_older(input logic [SEQ_WIDTH-1:0] a,
                                    input logic [SEQ_WIDTH-1:0] b);
    logic [SEQ_WIDTH-1:0] diff;
    diff = a - b;
    return diff[SEQ_WIDTH-1];
  endfunction

  logic [0:CHANNELS-1] age_cand;
  logic                age_found;
  logic [CH_W-1:0]     age_idx;
  logic                any_valid;
  logic [CH_W-1:0]     first_valid_idx;
  logic [CH_W-1:0]     grant_idx;
  logic                accept;

  // A channel is a candidate when it is not younger than any higher-index
  // valid channel and strictly older than every lower-index valid channel.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write,
    // otherwise the tool infers a latch to hold the old value.
    age_cand = in_valid;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int j = 0; j < CHANNELS; j++) begin
        if (j != i && in_valid[j]) begin
          if (j < i) begin
            if (!is_older(in_seq[i], in_seq[j])) age_cand[i] = 1'b0;
          end else if (is_older(in_seq[j], in_seq[i])) begin
            age_cand[i] = 1'b0;
          end
        end
      end
    end
  end

  // Lowest-index candidate wins; lowest valid channel is the fallback when
  // tags span more than half the sequence space and no total order exists.
  always_comb begin
    age_found       = 1'b0;
    age_idx         = '0;
    any_valid       = 1'b0;
    first_valid_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (age_cand[i]) begin
        age_found = 1'b1;
        age_idx   = CH_W'(i);
      end
      if (in_valid[i]) begin
        any_valid       = 1'b1;
        first_valid_idx = CH_W'(i);
      end
    end
    if (!age_found) age_idx = first_valid_idx;
  end

`ifdef RS_ARB_STARVE_GUARD_EN
  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt [CHANNELS];
  logic             starve_hit;
  logic [CH_W-1:0]  starve_idx;

  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && wait_cnt[i] == CNT_MAX) begin
        starve_hit = 1'b1;
        starve_idx = CH_W'(i);
      end
    end
  end

  assign grant_idx = starve_hit ? starve_idx : age_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_ready[i] || !in_valid[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign grant_idx = age_idx;
`endif

  // Held low through reset so no station sees a handshake it cannot complete.
  assign accept = rst & (~out_valid | out_ready);

  always_comb begin
    in_ready = '0;
    if (accept && any_valid) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      out_valid   <= 1'b0;
      out_rs_id   <= '0;
      out_op      <= '0;
      out_control <= '0;
      out_channel <= '0;
    end else if (accept) begin
      out_valid <= any_valid;
      if (any_valid) begin
        out_rs_id   <= in_rs_id[grant_idx];
        out_op      <= in_op[grant_idx];
        out_control <= in_control[grant_idx];
        out_channel <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Scoreboard bench for rs_issue_arbiter: directed stimulus pushes expected
// issues (with their cycle), a negedge monitor pops and compares them.
module tb_rs_issue_arbiter;

  localparam int CH = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [0:CH-1]         in_valid;
  logic [0:CH-1]         in_ready;
  logic [CH-1:0][4:0]    in_rs_id;
  logic [CH-1:0][5:0]    in_seq;
  logic [CH-1:0][31:0]   in_op;
  logic [CH-1:0][15:0]   in_control;
  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_rs_id;
  logic [31:0]           out_op;
  logic [15:0]           out_control;
  logic [1:0]            out_channel;

  rs_issue_arbiter #(
    .CHANNELS(CH), .OP_WIDTH(32), .RS_ID_WIDTH(5), .CTRL_WIDTH(16),
    .SEQ_WIDTH(6), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_id(in_rs_id), .in_seq(in_seq), .in_op(in_op), .in_control(in_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_id(out_rs_id), .out_op(out_op), .out_control(out_control),
    .out_channel(out_channel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cyc;
    logic [1:0]  ch;
    logic [4:0]  id;
    logic [31:0] op;
    logic [15:0] ctrl;
  } item_t;

  item_t exp_q[$];
  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  logic  stream_mode = 1'b0;
  int    nxt_seq;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Entry fields are a fixed function of (channel, seq) so expectations can
  // be written as hand-computed (channel, seq, cycle) triples.
  function automatic item_t mk(input int ch, input int seq, input int c);
    item_t it;
    it.cyc  = 16'(c);
    it.ch   = 2'(ch);
    it.id   = 5'(seq);
    it.op   = {16'hA5A5, 8'(ch), 2'b00, 6'(seq)};
    it.ctrl = {2'(ch), 8'h3C, 6'(seq)};
    return it;
  endfunction

  task automatic offer(input int ch, input int seq);
    item_t it;
    it = mk(ch, seq, 0);
    in_valid[ch]   = 1'b1;
    in_seq[ch]     = 6'(seq);
    in_rs_id[ch]   = it.id;
    in_op[ch]      = it.op;
    in_control[ch] = it.ctrl;
  endtask

  task automatic expect_issue(input int ch, input int seq, input int c);
    exp_q.push_back(mk(ch, seq, c));
  endtask

  task automatic handle_grant(input int ch);
    if (stream_mode && ch < 2) begin
      offer(ch, nxt_seq);
      nxt_seq++;
    end else begin
      in_valid[ch] = 1'b0;
    end
  endtask

  // Each step: sample handshakes mid-cycle, then retire taken entries.
  task automatic run_cycles(input int n);
    logic [0:CH-1] rdy;
    repeat (n) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) if (rdy[i]) handle_grant(i);
    end
  endtask

  always @(negedge clk) begin
    item_t act, e;
    if (rst === 1'b1) begin
      check("in_ready_onehot0", 128'($onehot0(in_ready)), 128'(1));
      if (out_valid && out_ready) begin
        act = {16'(cyc), out_channel, out_rs_id, out_op, out_control};
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_issue: got %0h required none", act);
        end else begin
          e = exp_q.pop_front();
          check("issue", 128'(act), 128'(e));
        end
      end
    end
  end

  initial begin
    int c;
    logic [0:CH-1] exp_rdy;
    rst        = 1'b0;
    out_ready  = 1'b1;
    in_valid   = '0;
    in_seq     = '0;
    in_rs_id   = '0;
    in_op      = '0;
    in_control = '0;

    // Reset with every channel offering, then release: ch1 (seq 3) granted at once.
    offer(0, 5); offer(1, 3); offer(2, 9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    c = cyc;
    expect_issue(1, 3, c + 1);
    expect_issue(0, 5, c + 2);
    expect_issue(2, 9, c + 3);
    @(negedge clk);
    exp_rdy = 3'b010;
    check("first_grant_same_cycle", 128'(in_ready), 128'(exp_rdy));
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    run_cycles(5);
    check("age_drained", 128'(exp_q.size()), 128'(0));

    // Wrap: 62 is older than 1 in a 6-bit tag space.
    offer(0, 62); offer(1, 1);
    c = cyc;
    expect_issue(0, 62, c + 1);
    expect_issue(1, 1, c + 2);
    run_cycles(5);
    check("wrap_drained", 128'(exp_q.size()), 128'(0));

    // Tie on ch0/ch2 plus three cycles of backpressure after the first load.
    out_ready = 1'b0;
    offer(0, 10); offer(2, 10);
    c = cyc;
    run_cycles(1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_channel", 128'(out_channel), 128'(0));
      check("bp_out_rs_id", 128'(out_rs_id), 128'(10));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    expect_issue(0, 10, c + 4);
    expect_issue(2, 10, c + 5);
    run_cycles(4);
    check("tie_drained", 128'(exp_q.size()), 128'(0));

    // ch2 stays youngest while ch0/ch1 keep refilling with older tags.
    stream_mode = 1'b1;
    nxt_seq     = 12;
    offer(0, 10); offer(1, 11); offer(2, 40);
    c = cyc;
    expect_issue(0, 10, c + 1);
    expect_issue(1, 11, c + 2);
    expect_issue(0, 12, c + 3);
    expect_issue(1, 13, c + 4);
`ifdef RS_ARB_STARVE_GUARD_EN
    expect_issue(2, 40, c + 5);
`else
    expect_issue(0, 14, c + 5);
`endif
    run_cycles(5);
    in_valid    = '0;
    stream_mode = 1'b0;
    run_cycles(4);
    check("starve_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule
